// File: rtl/l1_stream_out.sv
// Streams the layer-1 feature map from the shared layer memory over valid/ready.
// Optional checksum output: define L1_CHECKSUM_EN.
module l1_stream_out #(
    parameter int unsigned MAP_W     = 32,
    parameter int unsigned MAP_H     = 32,
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter logic [2:0]  SRC_SEL   = 3'd3,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    output logic [2:0]  csel,
    input  logic [19:0] cdata_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data,
    output logic        out_last
`ifdef L1_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [11:0] LAST_IDX = 12'(MAP_W * MAP_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t      state_q;
    logic        busy_q, done_q, crd_q, last_iss_q;
    logic        inflight_q, inflight_last_q;
    logic [11:0] rd_idx_q, caddr_q;
    logic [2:0]  csel_q;
    logic [19:0] fifo_data_q [DEPTH];
    logic        fifo_last_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic [PW+1:0] outstanding;
    logic        push, pop, issue;
`ifdef L1_CHECKSUM_EN
    logic [31:0] checksum_q;
`endif

    // Credit covers the word being read this cycle and the one landing from memory.
    always_comb begin
        push        = inflight_q;
        pop         = (count_q != '0) && out_ready;
        outstanding = (PW+2)'(count_q) + (PW+2)'(crd_q) + (PW+2)'(inflight_q);
        issue       = (state_q == S_READ) && (outstanding < (PW+2)'(DEPTH));
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            crd_q           <= 1'b0;
            last_iss_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_idx_q        <= '0;
            caddr_q         <= '0;
            csel_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
`ifdef L1_CHECKSUM_EN
            checksum_q      <= '0;
`endif
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= cdata_rd;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
`ifdef L1_CHECKSUM_EN
                checksum_q <= checksum_q + {12'b0, fifo_data_q[rd_ptr_q]};
`endif
            end
            count_q         <= count_d;
            inflight_q      <= crd_q;
            inflight_last_q <= last_iss_q;
            crd_q           <= 1'b0;
            last_iss_q      <= 1'b0;
            done_q          <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_READ;
                        busy_q   <= 1'b1;
                        rd_idx_q <= '0;
`ifdef L1_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (issue) begin
                        crd_q      <= 1'b1;
                        caddr_q    <= BASE_ADDR + rd_idx_q;
                        csel_q     <= SRC_SEL;
                        rd_idx_q   <= rd_idx_q + 12'd1;
                        last_iss_q <= (rd_idx_q == LAST_IDX);
                        if (rd_idx_q == LAST_IDX) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_last_q[rd_ptr_q]) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        csel_q  <= '0;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign crd       = crd_q;
    assign caddr_rd  = caddr_q;
    assign csel      = csel_q;
    assign out_valid = (count_q != '0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = fifo_last_q[rd_ptr_q];
`ifdef L1_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_l1_stream_out.sv
// Directed bench for l1_stream_out: full map, back-pressure, random stalls, reset abort, small map.
// Checksum checks are compiled in when L1_CHECKSUM_EN is defined.
module tb_l1_stream_out;

    localparam int N     = 1024;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, start1 = 1'b0;
    logic        out_ready = 1'b0, out_ready1 = 1'b0;
    logic [19:0] cdata_rd = '0, cdata1 = '0;
    logic        busy, done, crd, out_valid, out_last;
    logic        busy1, done1, crd1, out_valid1, out_last1;
    logic [11:0] caddr_rd, caddr1;
    logic [2:0]  csel, csel1;
    logic [19:0] out_data, out_data1;
`ifdef L1_CHECKSUM_EN
    logic [31:0] checksum, checksum1;
`endif
    logic [19:0] mem [4096];

    int n_cmp = 0;
    int n_err = 0;

    l1_stream_out #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
`ifdef L1_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    l1_stream_out #(.MAP_W(4), .MAP_H(2), .BASE_ADDR(12'h100)) dut_small (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .crd(crd1), .caddr_rd(caddr1), .csel(csel1), .cdata_rd(cdata1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1)
`ifdef L1_CHECKSUM_EN
        , .checksum(checksum1)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory shared by both instances.
    always @(posedge clk) begin
        if (crd)  cdata_rd <= mem[caddr_rd];
        if (crd1) cdata1   <= mem[caddr1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_mem(input int pat);
        for (int a = 0; a < 4096; a++)
            mem[a] = (pat != 0) ? 20'hFFFFF - 20'(a) : 20'(a);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_crd"},   crd, 0);
        chk({tag, "_caddr"}, caddr_rd, 0);
        chk({tag, "_csel"},  csel, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_last"},  out_last, 0);
`ifdef L1_CHECKSUM_EN
        chk({tag, "_cksum"}, checksum, 0);
`endif
    endtask

    // mode 0: ready high, 1: 10-cycle stall after word 2, 2: random ready.
    task automatic run_map(input int mode, input int pat, input bit dbl_start, input int abort_at);
        int idx = 0, n_iss = 0, done_cnt = 0, cyc = 0, t_crd = -1, t_val = -1;
        int stall = 0, guard = 0;
        bit seen;
        logic [31:0] sum = 0;
        logic [19:0] ew;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_start", busy, 1);
        while (idx < N && guard < 20000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            if (crd) begin
                chk("rd_addr", caddr_rd, n_iss);
                chk("csel", csel, 3);
                n_iss++;
                chk("credit", (n_iss - idx) <= DEPTH, 1);
                if (t_crd < 0) t_crd = cyc;
            end
            if (out_valid && t_val < 0) t_val = cyc;
            if (done) done_cnt++;
            start = dbl_start && (cyc == 50);
            case (mode)
                1: begin
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        chk("bp_valid", out_valid, 1);
                        chk("bp_data", out_data, 3);
                        stall--;
                    end else out_ready = 1'b1;
                end
                2: out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                ew = (pat != 0) ? 20'hFFFFF - 20'(idx) : 20'(idx);
                chk("data", out_data, ew);
                chk("last", out_last, idx == N - 1);
                sum += 32'(ew);
                idx++;
                if (mode == 1 && idx == 3) stall = 10;
            end
            @(negedge clk);
            cyc++;
            guard++;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            chk("abort_idx", idx, abort_at);
            #2 reset = 1'b0;
            #1 check_all_zero("rst_mid");
            @(negedge clk);
            @(negedge clk) reset = 1'b1;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen |= out_valid | done | crd | busy;
            end
            chk("rst_residual", seen, 0);
            chk("rst_no_done", done_cnt, 0);
            return;
        end
        chk("words", idx, N);
        chk("issued", n_iss, N);
        chk("first_lat", t_val - t_crd, 2);
        chk("done_early", done_cnt, 0);
        chk("done", done, 1);
        chk("busy_in_done", busy, 1);
        chk("csel_done", csel, 0);
`ifdef L1_CHECKSUM_EN
        chk("checksum", checksum, sum);
        if (pat == 0) chk("checksum_ref", checksum, 32'h0007FE00);
`endif
        start = 1'b1;  // coincides with done: must be ignored
        @(negedge clk) start = 1'b0;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("valid_idle", out_valid, 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= crd | busy;
        end
        chk("no_restart", seen, 0);
`ifdef L1_CHECKSUM_EN
        chk("checksum_hold", checksum, sum);
`endif
    endtask

    task automatic run_small();
        int idx = 0, n_iss = 0, guard = 0, dcnt = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        out_ready1 = 1'b1;
        while (idx < 8 && guard < 200) begin
            if (crd1) begin
                chk("s_addr", caddr1, 12'h100 + n_iss);
                chk("s_csel", csel1, 3);
                n_iss++;
            end
            if (done1) dcnt++;
            if (out_valid1 && out_ready1) begin
                chk("s_data", out_data1, 20'h100 + idx);
                chk("s_last", out_last1, idx == 7);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        chk("s_words", idx, 8);
        chk("s_issued", n_iss, 8);
        chk("s_early_done", dcnt, 0);
        chk("s_done", done1, 1);
`ifdef L1_CHECKSUM_EN
        chk("s_checksum", checksum1, 32'h0000081C);
`endif
        @(negedge clk);
        chk("s_busy", busy1, 0);
        chk("s_done_pulse", done1, 0);
    endtask

    initial begin
        load_mem(0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        run_map(0, 0, 1'b0, -1);
        run_map(1, 0, 1'b1, -1);
        load_mem(1);
        run_map(2, 1, 1'b0, -1);
        load_mem(0);
        run_map(0, 0, 1'b0, 500);
        run_map(0, 0, 1'b0, -1);
        run_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_stream_out.md
Name: l1_stream_out

Overview:
- Downstream consumer of the convolution/max-pool engine.
- After that engine finishes, this block reads the layer-1 (max-pooled, 32x32) feature map out of the shared layer memory through the csel/crd read port.
- It streams the words in raster order over a valid/ready interface to the next stage (flatten/FC or host capture).
- An internal FIFO decouples the 1-cycle memory read latency from consumer back-pressure.

Parameters:
- MAP_W, 32, feature-map width in words.
- MAP_H, 32, feature-map height in words.
- BASE_ADDR, 12'h000, memory address of map element (0,0).
- SRC_SEL, 3'd3, csel value selecting the layer-1 memory.
- DEPTH, 4, output FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a readout.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- crd  out  1  memory read strobe.
- caddr_rd  out  12  memory read address.
- csel  out  3  memory select.
- cdata_rd  in  20  read data, valid the cycle after crd/caddr_rd are sampled high.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_data  out  20  feature word, unsigned.
- out_last  out  1  high with the final word (index MAP_W*MAP_H-1).

Behaviour:
- Reset (reset=0, async): all state cleared.
  - Outputs: busy=0, done=0, crd=0, caddr_rd=0, csel=0, out_valid=0, out_data=0, out_last=0.
  - FIFO is emptied; the read counter and in-flight flag are cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 → READ.
  - busy goes 1 on the next edge; the read index rd_idx is set to 0.
  - start while busy=1 is ignored.
- READ:
  - Each cycle where fifo_count + inflight < DEPTH, drive crd=1, caddr_rd=BASE_ADDR+rd_idx, csel=SRC_SEL (registered outputs), then increment rd_idx.
  - inflight marks an issued read whose data has not yet been written to the FIFO.
  - Otherwise drive crd=0; caddr_rd and csel hold their values.
  - After the read at rd_idx = MAP_W*MAP_H-1 is issued → DRAIN.
- FIFO write: the cycle after an issue, cdata_rd is pushed together with a last tag (set for the final index).
  - The credit rule guarantees the FIFO never overflows.
  - No data is ever dropped.
- FIFO read: out_valid = (fifo_count != 0); out_data and out_last show the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - With out_ready held high, sustained throughput is 1 word/cycle.
  - First out_valid appears 2 cycles after the first crd.
- Stream stability: while out_valid=1 && out_ready=0, out_data and out_last stay stable.
- DRAIN: crd=0.
  - When a word with out_last is popped → DONE.
- DONE: one cycle.
  - done=1, busy=0 on the following edge, then → IDLE.
  - csel returns to 0.
- Address range: rd_idx width is 12 bits; MAP_W*MAP_H <= 4096 - BASE_ADDR. Address arithmetic never wraps.
- Reset mid-operation: everything aborts immediately.
  - No done pulse is produced.
  - No residual words appear after reset is released.
- Start arriving on the same cycle as done: ignored (busy is still 1).

Optional Feature:
- Macro: L1_CHECKSUM_EN.
- When defined:
  - Adds output checksum [31:0].
  - The unsigned sum of all popped out_data words since the last accepted start, zero-extended, wrapping mod 2^32.
  - Cleared on start acceptance; stable from the done pulse until the next start.
  - Reset value 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Full readout, no back-pressure. Stimulus: L1 memory preloaded word[a]=a for a=0..1023, out_ready=1, start pulse. Required response:
  - 1024 words 0..1023 in order; out_last only on word 1023.
  - crd addresses 0x000..0x3FF, each exactly once.
  - done one cycle after the last pop; busy=0 afterwards.
- Back-pressure. Stimulus: out_ready=0 for 10 cycles after word 2 is accepted. Required response:
  - out_data=3 held stable with out_valid=1.
  - crd stops after at most DEPTH outstanding words.
  - Resuming out_ready gives 3,4,5… with no gaps or duplicates.
- Random stalls. Stimulus: out_ready random 50% with preloaded word[a]=20'hFFFFF-a. Required response:
  - Exact sequence FFFFF..FFC00.
  - FIFO never overflows (assert fifo_count<=DEPTH).
- Small map. Stimulus: MAP_W=4, MAP_H=2, BASE_ADDR=12'h100. Required response:
  - Reads 0x100..0x107.
  - 8 words; out_last on the 8th.
- Reset and start rules. Stimulus:
  - Assert reset at word 500, release, then start again.
  - Separately, pulse start again while busy.
  - Required response:
    - On reset, all outputs go to 0 immediately, with no done pulse.
    - The restarted readout begins at address 0.
    - A start while busy is ignored, giving a single readout and a single done.
- L1_CHECKSUM_EN. Stimulus: word[a]=a. Required response:
  - checksum=32'h0007FE00 at done.
  - A second run gives the same value (checksum is cleared on start).
